// File: rtl/mac_div_pkg.sv
// rtl/mac_div_pkg.sv - shared constants and types for the MAC accumulator divider
// Purpose : state encoding, default widths and the divide-by-zero quotient value
//           used by mac_acc_divider and mac_div_step.
// Ports   : none (package)
package mac_div_pkg;

  localparam int DW_DEF = 8;  // dividend / quotient width (accumulator width)
  localparam int VW_DEF = 4;  // divisor / remainder width (multiplier operand width)

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor
  localparam logic [DW_DEF-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/mac_div_step.sv
// rtl/mac_div_step.sv - one combinational restoring-division step
// Purpose : shifts the next dividend bit into the partial remainder and
//           conditionally subtracts the divisor, yielding one quotient bit.
// Ports   : rem_in  [VW-1:0] in   partial remainder from the previous step
//           bit_in           in   next dividend bit (MSB first)
//           divisor [VW-1:0] in   divisor
//           rem_out [VW-1:0] out  partial remainder after this step
//           q_bit            out  quotient bit produced by this step
module mac_div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0]   r_ext;
  logic [VW-1:0] r_sub;

  always_comb begin
    r_ext = {rem_in, bit_in};
    // A set top bit means r_ext already exceeds any VW-bit divisor.
    q_bit = r_ext[VW] | (r_ext[VW-1:0] >= divisor);
    // rem_in < divisor, so r_ext - divisor < divisor: the low VW bits of the
    // modular difference are the exact result.
    r_sub = r_ext[VW-1:0] - divisor;
    rem_out = q_bit ? r_sub : r_ext[VW-1:0];
  end

endmodule

// File: rtl/mac_acc_divider.sv
// rtl/mac_acc_divider.sv - sequential restoring divider for the MAC accumulator
// Purpose : divides the DW-bit accumulator value by a VW-bit operand, one
//           quotient bit per clock, with valid/ready handshakes on both sides.
//           Optional macro DIV_ZERO_FAST_EN: a zero divisor goes straight
//           from IDLE to DONE instead of running the full BUSY sequence.
// Ports   : clk                 in   clock, rising edge
//           rst_n               in   synchronous reset, active-low
//           in_valid / in_ready in/out  operand handshake
//           dividend  [DW-1:0]  in   unsigned numerator
//           divisor   [VW-1:0]  in   unsigned denominator
//           out_valid/out_ready out/in  result handshake
//           quotient  [DW-1:0]  out  floor(dividend/divisor), all ones on /0
//           remainder [VW-1:0]  out  dividend mod divisor, 0 on /0
//           div_zero            out  divisor was zero for this result
module mac_acc_divider
  import mac_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] ZERO_Q = {DW{DIV_ZERO_Q[0]}};

  state_t        state_q, state_d;
  // q_q holds the not-yet-consumed dividend bits at the top and the quotient
  // bits shifting in at the bottom; after DW steps it is the quotient.
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  logic [VW-1:0] step_rem;
  logic          step_q_bit;
  logic          last_step;

  assign last_step = (cnt_q == CW'(DW - 1));

  mac_div_step #(.VW(VW)) u_step (
    .rem_in  (rem_q),
    .bit_in  (q_q[DW-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = (divisor == '0) ? S_DONE : S_BUSY;
`else
          state_d = S_BUSY;
`endif
        end
      end
      S_BUSY:  if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    quotient  = q_q;
    remainder = rem_q;
    div_zero  = dz_q;
  end

  // Datapath next values
  always_comb begin
    q_d   = q_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          q_d   = dividend;
          rem_d = '0;
          dvs_d = divisor;
          cnt_d = '0;
          dz_d  = (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) q_d = ZERO_Q;
`endif
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (dz_q) begin
          // Keep the remainder pinned at zero so the /0 result is clean.
          q_d   = last_step ? ZERO_Q : {q_q[DW-2:0], 1'b1};
          rem_d = '0;
        end else begin
          q_d   = {q_q[DW-2:0], step_q_bit};
          rem_d = step_rem;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_divider.sv
// tb/tb_mac_acc_divider.sv - self-checking bench for mac_acc_divider
module tb_mac_acc_divider;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mac_acc_divider #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [7:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Edges from the accept edge until out_valid is seen (sampled 1ns after edges).
  function automatic int exp_latency(input logic [3:0] dv);
`ifdef DIV_ZERO_FAST_EN
    if (dv == 4'd0) return 0;  // accept edge itself lands in DONE
`endif
    return 8;
  endfunction

  task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic dz, output int lat);
    int guard;
    guard = 0;
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t       vecs[$];
  logic [7:0] rq;
  logic [3:0] rr;
  logic       rdz;
  int         lat;

  // random phase
  logic [11:0] pend[$];
  logic [11:0] item;
  int          sent, got, cycles;
  logic        acc;
  logic [7:0]  mq;
  logic [3:0]  mr;
  logic        mdz;
  logic        saw_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;

    vecs.push_back('{8'd200, 4'd7,  8'd28,  4'd4,  1'b0});
    vecs.push_back('{8'd225, 4'd15, 8'd15,  4'd0,  1'b0});
    vecs.push_back('{8'd255, 4'd1,  8'd255, 4'd0,  1'b0});
    vecs.push_back('{8'd3,   4'd9,  8'd0,   4'd3,  1'b0});
    vecs.push_back('{8'd13,  4'd0,  8'd255, 4'd0,  1'b1});
    vecs.push_back('{8'd0,   4'd5,  8'd0,   4'd0,  1'b0});
    vecs.push_back('{8'd254, 4'd15, 8'd16,  4'd14, 1'b0});
    vecs.push_back('{8'd0,   4'd0,  8'd255, 4'd0,  1'b1});
    vecs.push_back('{8'd128, 4'd8,  8'd16,  4'd0,  1'b0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready",  in_ready,  1);
    check("rst out_valid", out_valid, 0);
    check("rst quotient",  quotient,  0);
    check("rst remainder", remainder, 0);
    check("rst div_zero",  div_zero,  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].dd, vecs[i].dv, rq, rr, rdz, lat);
      check($sformatf("vec%0d quotient", i),  rq,  vecs[i].exp_q);
      check($sformatf("vec%0d remainder", i), rr,  vecs[i].exp_r);
      check($sformatf("vec%0d div_zero", i),  rdz, vecs[i].exp_dz);
      check($sformatf("vec%0d latency", i),   lat, exp_latency(vecs[i].dv));
      check($sformatf("vec%0d idle after", i), in_ready, 1);
    end

    // Back-pressure, plus in_valid and out_ready together in DONE
    dividend = 8'd200; divisor = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp busy in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp latency", lat, 8);
    dividend = 8'd77; divisor = 4'd5; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", out_valid, 1);
      check("bp quotient",  quotient,  28);
      check("bp remainder", remainder, 4);
      check("bp in_ready",  in_ready,  0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready",  in_ready,  1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next accepted", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp2 quotient",  quotient,  15);
    check("bp2 remainder", remainder, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of BUSY
    dividend = 8'd100; divisor = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid rst in_ready",  in_ready,  1);
    check("mid rst out_valid", out_valid, 0);
    check("mid rst quotient",  quotient,  0);
    check("mid rst remainder", remainder, 0);
    check("mid rst div_zero",  div_zero,  0);
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid rst no pulse", saw_valid, 0);
    run_op(8'd100, 4'd3, rq, rr, rdz, lat);
    check("post rst quotient",  rq, 33);
    check("post rst remainder", rr, 1);

    // Random back-to-back against arithmetic model
    sent = 0; got = 0; cycles = 0;
    out_ready = 1'b1;
    dividend = 8'($urandom);
    divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    in_valid = 1'b1;
    while (got < 1000 && cycles < 20000) begin
      if (out_valid) begin
        if (pend.size() == 0) begin
          check("rnd unexpected result", 1, 0);
        end else begin
          item = pend.pop_front();
          if (item[3:0] == 4'd0) begin
            mq = 8'hFF; mr = 4'd0; mdz = 1'b1;
          end else begin
            mq = 8'(int'(item[11:4]) / int'(item[3:0]));
            mr = 4'(int'(item[11:4]) % int'(item[3:0]));
            mdz = 1'b0;
          end
          check($sformatf("rnd %0d/%0d quotient", item[11:4], item[3:0]), quotient, mq);
          check($sformatf("rnd %0d/%0d remainder", item[11:4], item[3:0]), remainder, mr);
          check($sformatf("rnd %0d/%0d div_zero", item[11:4], item[3:0]), div_zero, mdz);
        end
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) begin
        pend.push_back({dividend, divisor});
        sent++;
        if (sent < 1000) begin
          dividend = 8'($urandom);
          divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check("rnd results received", got, 1000);
    check("rnd accepted == results", sent, got);
    check("rnd throughput bound", (cycles <= 1000 * 10 + 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
